// File: rtl/jtag_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_shift_ctrl
// Description : On-chip JTAG master. Divides sys_clk into TCK, walks the TAP
//               from Run-Test/Idle and performs IR/DR scans of up to 32 bits
//               (LSB first), TAP resets and idle clocking. Every command
//               returns one response carrying the captured TDO bits.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_shift_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam int              C_CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CLK_DIV - 1);
  localparam int              C_SEQ_W     = 38;   // longest op: IR with 32 bits
  localparam logic [1:0]      C_OP_RESET  = 2'b00;
  localparam logic [1:0]      C_OP_IR     = 2'b01;
  localparam logic [1:0]      C_OP_DR     = 2'b10;
  localparam logic [C_SEQ_W-1:0] C_RESET_TMS = C_SEQ_W'(6'b01_1111);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;       // sys_clk cycles within a TCK half-period
  logic [5:0]           r_idx;       // current TCK index within the op
  logic [5:0]           r_total;     // TCK count of the op
  logic [C_SEQ_W-1:0]   r_tms_seq;   // TMS value per TCK, bit 0 first
  logic [C_SEQ_W-1:0]   r_tdi_seq;   // TDI value per TCK
  logic [C_SEQ_W-1:0]   r_sh_mask;   // TCKs on which TDO is captured
  logic [31:0]          r_cap;
  logic [4:0]           r_sh_pos;
  logic                 r_is_cmd;    // 0 while running the power-up TAP reset

  logic [5:0]           w_len;
  logic [31:0]          w_mask;
  logic [C_SEQ_W-1:0]   w_tms_seq;
  logic [C_SEQ_W-1:0]   w_tdi_seq;
  logic [C_SEQ_W-1:0]   w_sh_mask;
  logic [5:0]           w_total;

  // Clamp the command length into 1..32 and build a mask of the shifted bits
  always_comb begin
    w_len = cmd_len;
    if (cmd_len == 6'd0) begin
      w_len = 6'd1;
    end else if (cmd_len > 6'd32) begin
      w_len = 6'd32;
    end
    w_mask = (w_len == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w_len) - 32'd1);
  end

  // Expand the incoming command into per-TCK TMS/TDI/capture sequences
  always_comb begin
    w_tms_seq = '0;
    w_tdi_seq = '0;
    w_sh_mask = '0;
    w_total   = w_len;
    case (cmd_op)
      C_OP_RESET: begin
        w_tms_seq = C_RESET_TMS;
        w_total   = 6'd6;
      end
      C_OP_DR: begin
        // 1,0,0 | shift bits with TMS=1 on the last | 1,0
        w_tms_seq = C_SEQ_W'(1) | (C_SEQ_W'(1) << (w_len + 6'd2))
                                | (C_SEQ_W'(1) << (w_len + 6'd3));
        w_tdi_seq = {6'd0, cmd_data & w_mask} << 3;
        w_sh_mask = {6'd0, w_mask} << 3;
        w_total   = w_len + 6'd5;
      end
      C_OP_IR: begin
        // 1,1,0,0 | shift bits with TMS=1 on the last | 1,0
        w_tms_seq = C_SEQ_W'(3) | (C_SEQ_W'(1) << (w_len + 6'd3))
                                | (C_SEQ_W'(1) << (w_len + 6'd4));
        w_tdi_seq = {6'd0, cmd_data & w_mask} << 4;
        w_sh_mask = {6'd0, w_mask} << 4;
        w_total   = w_len + 6'd6;
      end
      default: begin
        // idle clocking: L TCKs with TMS=0, nothing captured
        w_total = w_len;
      end
    endcase
  end

  // Controller FSM: command intake, TCK half-period loop, response hold
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_total   <= '0;
      r_tms_seq <= '0;
      r_tdi_seq <= '0;
      r_sh_mask <= '0;
      r_cap     <= '0;
      r_sh_pos  <= '0;
      r_is_cmd  <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_tms_seq <= C_RESET_TMS;
          r_tdi_seq <= '0;
          r_sh_mask <= '0;
          r_total   <= 6'd6;
          r_idx     <= '0;
          r_cnt     <= '0;
          r_cap     <= '0;
          r_sh_pos  <= '0;
          r_is_cmd  <= 1'b0;
          tck       <= 1'b0;
          tms       <= 1'b1;
          tdi       <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          r_state   <= ST_LO;
        end
        ST_IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_tms_seq <= w_tms_seq;
            r_tdi_seq <= w_tdi_seq;
            r_sh_mask <= w_sh_mask;
            r_total   <= w_total;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_cap     <= '0;
            r_sh_pos  <= '0;
            r_is_cmd  <= 1'b1;
            tms       <= w_tms_seq[0];
            tdi       <= w_tdi_seq[0];
            r_state   <= ST_LO;
          end
        end
        ST_LO: begin
          if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            tck     <= 1'b1;
            r_state <= ST_HI;
            // TDO is captured on the same edge that raises TCK
            if (r_sh_mask[r_idx]) begin
              r_cap[r_sh_pos] <= tdo;
              r_sh_pos        <= r_sh_pos + 5'd1;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        ST_HI: begin
          if (r_cnt == C_CNT_LAST) begin
            r_cnt <= '0;
            tck   <= 1'b0;
            if (r_idx == r_total - 6'd1) begin
              tms <= 1'b0;
              tdi <= 1'b0;
              if (r_is_cmd) begin
                r_state <= ST_RESP;
              end else begin
                busy    <= 1'b0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_idx   <= r_idx + 6'd1;
              tms     <= r_tms_seq[r_idx + 6'd1];
              tdi     <= r_tdi_seq[r_idx + 6'd1];
              r_state <= ST_LO;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= r_cap;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
